fetch_queue_unit: RTL and testbench
===================================

// Module: fetch_queue_unit
// PURPOSE
//  Instruction-fetch front end of the pipelined RISC-V core: owns the PC, issues
//  word reads to synchronous instruction memory, buffers {pc,instr} pairs in a
//  small FIFO and hands them to the IF/ID register over a valid/ready handshake.
//  Accepts redirects (taken branch/jump) from execute and flushes all wrong-path work.
// PARAMETERS
//  XLEN      32   address/instruction width
//  RESET_PC  0    PC value loaded on reset
//  DEPTH     4    FIFO entries; power of two, >= 2
// PORTS
//  clk             in   1     clock; all state updates on rising edge
//  rst             in   1     synchronous, active-high reset
//  imem_req        out  1     read request this cycle
//  imem_addr       out  XLEN  byte address of request (bits[1:0] always 0)
//  imem_rdata      in   XLEN  read data; valid exactly 1 cycle after imem_req
//  redirect_valid  in   1     execute stage: branch taken / jump
//  redirect_pc     in   XLEN  redirect target
//  id_valid        out  1     FIFO head valid
//  id_ready        in   1     decode side accepts head
//  id_instr        out  XLEN  head instruction
//  id_pc           out  XLEN  head PC
// BEHAVIOUR
//  - Reset: pc=RESET_PC, FIFO empty, inflight=0, epoch=0; imem_req=0, id_valid=0,
//    id_instr=0, id_pc=0 during and in the cycle of reset. Reset beats redirect.
//  - Issue: imem_req=1 when !rst && !redirect_valid && (count+inflight < DEPTH);
//    imem_addr=pc; pc<=pc+4 (mod 2^XLEN wrap) on issue. inflight<=imem_req.
//  - Response: cycle after issue, if the tagged epoch still matches, push
//    {pc_of_req, imem_rdata} into FIFO. Space is guaranteed by issue accounting.
//  - Latency: first req in cycle 0 after reset release; id_valid=1 in cycle 2.
//    No bypass: data always passes through the FIFO.
//  - Pop when id_valid && id_ready. Push and pop in same cycle allowed at any
//    count incl. full (count unchanged). count in [0,DEPTH]; id_valid=(count!=0).
//  - Outputs driven from FIFO head; stable while id_valid && !id_ready.
//  - Redirect (single-cycle pulse, may repeat): same edge -> FIFO cleared,
//    epoch toggles (inflight response discarded), pc<=redirect_pc & ~3,
//    imem_req=0 that cycle. Next cycle: imem_req=1 with imem_addr=redirect_pc&~3.
//    Pop in the redirect cycle is ignored (id_valid forced 0 in redirect cycle).
//  - Back-to-back redirects: last one wins; no stale instruction ever reaches id_*.
//  - Pointers wrap modulo DEPTH; occupancy counter width clog2(DEPTH)+1.
// CONFIGURATION
//  FETCH_PERF_CNT_EN defined: adds outputs perf_stall_cycles[31:0] (cycles with
//    id_valid=0 and !rst) and perf_redirects[31:0] (accepted redirects); both
//    reset to 0, saturate at 2^32-1.
//  Undefined: ports and counters absent; all other behaviour identical.
// TESTING
//  1. rst 2 cycles, id_ready=1, imem returns addr>>2 -> imem_addr 0,4,8..; id_valid
//     from cycle 2; id_pc 0,4,8 with id_instr 0,1,2, one per cycle.
//  2. id_ready=0 from reset -> after 4 pushes count=4, imem_req=0, pc=0x10;
//     raise id_ready -> pops 0,4,8,0xC then fetch resumes at 0x10.
//  3. Steady stream, redirect_valid=1 redirect_pc=0x40 in cycle 6 -> cycle 6
//     id_valid=0, cycle 7 imem_addr=0x40, first id_pc after is 0x40; no 0x18..0x1C.
//  4. redirect_pc=0x103 -> fetch at 0x100; redirects at 0x40 then 0x80 back to
//     back -> only 0x80 stream delivered.
//  5. rst and redirect_valid asserted together -> pc=RESET_PC, next req addr 0.
//  6. FETCH_PERF_CNT_EN: run test 3 -> perf_redirects=1, perf_stall_cycles=
//     2 (startup) + redirect bubble count; all 0 after mid-run rst.

Source files
------------

// File: rtl/fetch_queue_unit_if.sv
// Fetch front-end bundle: instruction-memory read port, execute redirect and IF/ID handshake.
// The master side is the fetch unit; the slave side is the memory/pipeline environment.
interface fetch_queue_unit_if #(
  parameter int XLEN = 32
);
  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic [XLEN-1:0] imem_rdata;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            id_valid;
  logic            id_ready;
  logic [XLEN-1:0] id_instr;
  logic [XLEN-1:0] id_pc;

  modport master (
    output imem_req, imem_addr, id_valid, id_instr, id_pc,
    input  imem_rdata, redirect_valid, redirect_pc, id_ready
  );

  modport slave (
    input  imem_req, imem_addr, id_valid, id_instr, id_pc,
    output imem_rdata, redirect_valid, redirect_pc, id_ready
  );
endinterface

// File: rtl/fetch_queue_unit.sv
// Instruction fetch: PC owner, 1-cycle imem reads, {pc,instr} FIFO toward decode, redirect flush.
// Optional FETCH_PERF_CNT_EN adds saturating stall/redirect counters.
module fetch_queue_unit #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int              DEPTH    = 4
) (
  input  logic               clk,
  input  logic               rst,
  fetch_queue_unit_if.master fq
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]        perf_stall_cycles,
  output logic [31:0]        perf_redirects
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fq_entry_t;

  fq_entry_t [DEPTH-1:0] mem_q;

  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] req_pc_q;
  logic            epoch_q, epoch_d;
  logic            req_epoch_q;
  logic            inflight_q;
  logic [PW-1:0]   wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0]   count_q, count_d;
  logic [CW:0]     occ;
  logic            redirect, issue, push, pop, head_vld;

  // Outstanding request is counted as occupied so its response always finds a slot.
  assign occ      = {1'b0, count_q} + {{CW{1'b0}}, inflight_q};
  assign redirect = fq.redirect_valid && !rst;
  assign issue    = !rst && !fq.redirect_valid && (occ < (CW+1)'(DEPTH));
  assign push     = inflight_q && (req_epoch_q == epoch_q) && !fq.redirect_valid;
  assign head_vld = !rst && !fq.redirect_valid && (count_q != '0);
  assign pop      = head_vld && fq.id_ready;

  assign fq.imem_req  = issue;
  assign fq.imem_addr = pc_q;
  assign fq.id_valid  = head_vld;
  assign fq.id_pc     = head_vld ? mem_q[rd_q].pc    : '0;
  assign fq.id_instr  = head_vld ? mem_q[rd_q].instr : '0;

  always_comb begin
    pc_d    = pc_q;
    epoch_d = epoch_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    count_d = count_q;
    if (redirect) begin
      pc_d    = fq.redirect_pc & ~XLEN'(3);
      epoch_d = ~epoch_q;
      wr_d    = '0;
      rd_d    = '0;
      count_d = '0;
    end else begin
      if (issue) pc_d = pc_q + XLEN'(4);
      if (push)  wr_d = wr_q + PW'(1);
      if (pop)   rd_d = rd_q + PW'(1);
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q        <= RESET_PC;
      epoch_q     <= 1'b0;
      req_epoch_q <= 1'b0;
      req_pc_q    <= '0;
      inflight_q  <= 1'b0;
      wr_q        <= '0;
      rd_q        <= '0;
      count_q     <= '0;
    end else begin
      pc_q        <= pc_d;
      epoch_q     <= epoch_d;
      req_epoch_q <= epoch_q;
      req_pc_q    <= pc_q;
      inflight_q  <= issue;
      wr_q        <= wr_d;
      rd_q        <= rd_d;
      count_q     <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && push) mem_q[wr_q] <= '{pc: req_pc_q, instr: fq.imem_rdata};
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (count_q <= CW'(DEPTH));
      assert (!(push && !pop && count_q == CW'(DEPTH)));
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] stall_q, redir_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= '0;
      redir_q <= '0;
    end else begin
      if (!head_vld && !(&stall_q)) stall_q <= stall_q + 32'd1;
      if (redirect && !(&redir_q))  redir_q <= redir_q + 32'd1;
    end
  end

  assign perf_stall_cycles = stall_q;
  assign perf_redirects    = redir_q;
`endif

endmodule

// File: tb/tb_fetch_queue_unit.sv
// Bench for fetch_queue_unit: per-cycle vector table plus hand sequences, PC scoreboard on handshakes.
module tb_fetch_queue_unit;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fetch_queue_unit_if #(.XLEN(32)) bus();

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_stall, perf_redir;
`endif

  fetch_queue_unit #(.XLEN(32), .RESET_PC(32'h0), .DEPTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .fq  (bus)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_stall_cycles (perf_stall),
    .perf_redirects    (perf_redir)
`endif
  );

  // Synchronous imem: word at address A holds A>>2.
  logic [31:0] last_addr;
  always @(posedge clk) last_addr <= bus.imem_addr;
  assign bus.imem_rdata = last_addr >> 2;

  typedef struct {
    bit          r;
    bit          rv;
    logic [31:0] rpc;
    bit          rdy;
    bit          ereq;
    logic [31:0] ea;
    bit          ev;
  } vec_t;

  vec_t        tbl[$];
  logic [31:0] sbq[$];
  int          checks = 0;
  int          errors = 0;

  function automatic vec_t mk(bit r, bit rv, logic [31:0] rpc, bit rdy,
                              bit ereq, logic [31:0] ea, bit ev);
    vec_t v;
    v.r = r; v.rv = rv; v.rpc = rpc; v.rdy = rdy;
    v.ereq = ereq; v.ea = ea; v.ev = ev;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Drive one cycle, check at negedge, then advance to just after the next rising edge.
  task automatic cyc(input vec_t v);
    logic [31:0] e;
    rst                = v.r;
    bus.redirect_valid = v.rv;
    bus.redirect_pc    = v.rpc;
    bus.id_ready       = v.rdy;
    @(negedge clk);
    chk("imem_req", {31'b0, bus.imem_req}, {31'b0, v.ereq});
    chk("id_valid", {31'b0, bus.id_valid}, {31'b0, v.ev});
    if (!v.r && (v.ereq || !v.rv)) chk("imem_addr", bus.imem_addr, v.ea);
    if (v.r) begin
      chk("rst_id_pc", bus.id_pc, 32'h0);
      chk("rst_id_instr", bus.id_instr, 32'h0);
    end
    if (v.r || v.rv) begin
      sbq.delete();
    end else begin
      if (bus.id_valid) begin
        chk("sb_nonempty", {31'b0, sbq.size() != 0}, 32'h1);
        if (sbq.size() != 0) begin
          e = v.rdy ? sbq.pop_front() : sbq[0];
          chk("id_pc", bus.id_pc, e);
          chk("id_instr", bus.id_instr, e >> 2);
        end
      end
      if (v.ereq) sbq.push_back(v.ea);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) cyc(mk(1, 0, 0, 1, 0, 0, 0));
  endtask

  initial begin
    rst = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    bus.id_ready       = 1'b1;

    // Streaming with decode always ready.
    for (int i = 0; i < 2; i++) tbl.push_back(mk(1, 0, 0, 1, 0, 0, 0));
    for (int k = 0; k < 8; k++) tbl.push_back(mk(0, 0, 0, 1, 1, 32'(4*k), k >= 2));
    // Decode stalled from reset: FIFO fills, fetch stops at 0x10, then drains.
    for (int i = 0; i < 2; i++) tbl.push_back(mk(1, 0, 0, 1, 0, 0, 0));
    for (int k = 0; k < 4; k++) tbl.push_back(mk(0, 0, 0, 0, 1, 32'(4*k), k >= 2));
    for (int k = 4; k < 7; k++) tbl.push_back(mk(0, 0, 0, 0, 0, 32'h10, 1));
    tbl.push_back(mk(0, 0, 0, 1, 0, 32'h10, 1));
    for (int k = 0; k < 5; k++) tbl.push_back(mk(0, 0, 0, 1, 1, 32'(32'h10 + 4*k), 1));

    @(posedge clk);
    #1;
    for (int i = 0; i < tbl.size(); i++) cyc(tbl[i]);

    // Single redirect mid-stream to 0x40.
    do_reset(2);
    for (int k = 0; k < 6; k++) cyc(mk(0, 0, 0, 1, 1, 32'(4*k), k >= 2));
    cyc(mk(0, 1, 32'h40, 1, 0, 0, 0));
    cyc(mk(0, 0, 0, 1, 1, 32'h40, 0));
    cyc(mk(0, 0, 0, 1, 1, 32'h44, 0));
    cyc(mk(0, 0, 0, 1, 1, 32'h48, 1));
    cyc(mk(0, 0, 0, 1, 1, 32'h4C, 1));
    cyc(mk(0, 0, 0, 1, 1, 32'h50, 1));
`ifdef FETCH_PERF_CNT_EN
    chk("perf_stall_t3", perf_stall, 32'd5);
    chk("perf_redir_t3", perf_redir, 32'd1);
    cyc(mk(1, 0, 0, 1, 0, 0, 0));
    chk("perf_stall_rst", perf_stall, 32'd0);
    chk("perf_redir_rst", perf_redir, 32'd0);
`endif

    // Unaligned redirect target, then two back-to-back redirects.
    do_reset(2);
    for (int k = 0; k < 4; k++) cyc(mk(0, 0, 0, 1, 1, 32'(4*k), k >= 2));
    cyc(mk(0, 1, 32'h103, 1, 0, 0, 0));
    cyc(mk(0, 0, 0, 1, 1, 32'h100, 0));
    cyc(mk(0, 0, 0, 1, 1, 32'h104, 0));
    cyc(mk(0, 0, 0, 1, 1, 32'h108, 1));
    cyc(mk(0, 0, 0, 1, 1, 32'h10C, 1));
    cyc(mk(0, 1, 32'h40, 1, 0, 0, 0));
    cyc(mk(0, 1, 32'h80, 1, 0, 0, 0));
    cyc(mk(0, 0, 0, 1, 1, 32'h80, 0));
    cyc(mk(0, 0, 0, 1, 1, 32'h84, 0));
    for (int k = 0; k < 3; k++) cyc(mk(0, 0, 0, 1, 1, 32'(32'h88 + 4*k), 1));

    // Reset together with redirect: reset wins. Then PC wraps past 2^32.
    cyc(mk(1, 1, 32'h80, 1, 0, 0, 0));
    for (int k = 0; k < 4; k++) cyc(mk(0, 0, 0, 1, 1, 32'(4*k), k >= 2));
    cyc(mk(0, 1, 32'hFFFF_FFF8, 1, 0, 0, 0));
    cyc(mk(0, 0, 0, 1, 1, 32'hFFFF_FFF8, 0));
    cyc(mk(0, 0, 0, 1, 1, 32'hFFFF_FFFC, 0));
    for (int k = 0; k < 3; k++) cyc(mk(0, 0, 0, 1, 1, 32'(4*k), 1));
`ifdef FETCH_PERF_CNT_EN
    chk("perf_stall_t5", perf_stall, 32'd5);
    chk("perf_redir_t5", perf_redir, 32'd1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
